// File: rtl/multichannel_rc_high_pass_filter.sv
// Time-multiplexed leaky RC high-pass filter: one shared multiplier steps every channel
// through OVERSAMPLE Euler sub-steps per audio strobe, with bypass, saturation and overrun flag.
module multichannel_rc_high_pass_filter #(
    parameter int CLOCK_RATE   = 50000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int CHANNELS     = 2,
    parameter int DATA_WIDTH   = 16,
    parameter int OVERSAMPLE   = 1,
    parameter int R            = 47000,
    parameter int C_35_SHIFTED = 113387,
    parameter int LEAK_SHIFT   = 12
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           audio_clk_en,
    input  logic                           bypass,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in,
    output logic [CHANNELS*DATA_WIDTH-1:0] out,
    output logic                           out_valid,
    output logic                           busy,
    output logic                           overrun
);
    localparam int IW = DATA_WIDTH + 18;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam longint RC_32    = (longint'(R) * longint'(C_35_SHIFTED)) >>> 3;
    localparam longint DT_32    = (longint'(1) <<< 32) / (longint'(SAMPLE_RATE) * longint'(OVERSAMPLE));
    localparam longint ALPHA_16 = (RC_32 <<< 16) / (RC_32 + DT_32);
    localparam longint LEAK_16  = 65536 - (65536 >> LEAK_SHIFT);

    localparam logic signed [17:0]   ALPHA_C = 18'(ALPHA_16);
    localparam logic signed [17:0]   LEAK_C  = 18'(LEAK_16);
    localparam logic signed [IW-1:0] SAT_MAX = IW'((longint'(1) <<< (DATA_WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(longint'(1) <<< (DATA_WIDTH - 1)));

    // A run must finish before the next strobe can arrive.
    if (3 * CHANNELS * OVERSAMPLE + 2 >= CLOCK_RATE / SAMPLE_RATE) begin : g_rate_check
        $error("multichannel_rc_high_pass_filter: sequencer too slow for SAMPLE_RATE");
    end

    typedef enum logic [2:0] {IDLE, LEAK, ALPHA, STORE, COMMIT} state_t;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [IW-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[DATA_WIDTH-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[DATA_WIDTH-1:0];
        else
            return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic signed [IW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{(IW - DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
    endfunction

    state_t state, state_next;
    logic [CW-1:0] ch;
    logic [SW-1:0] sub;
    logic          last_sub, last_ch;
    logic          bypass_latched;
    logic          vld_p0;

    logic signed [DATA_WIDTH-1:0] x_new  [CHANNELS];
    logic signed [DATA_WIDTH-1:0] x_prev [CHANNELS];
    logic signed [DATA_WIDTH-1:0] y      [CHANNELS];
    logic signed [DATA_WIDTH-1:0] res_p0 [CHANNELS];

    logic signed [IW-1:0]    t_p0, p_p1, dx, mul_b, mul_q;
    logic signed [17:0]      mul_a;
    logic signed [IW+17:0]   prod;

    assign busy     = (state != IDLE);
    assign last_sub = (sub == SW'(OVERSAMPLE - 1));
    assign last_ch  = (ch == CW'(CHANNELS - 1));

    assign prod  = (IW+18)'(mul_a) * (IW+18)'(mul_b);
    assign mul_q = IW'(prod >>> 16);

    always_comb begin
        state_next = state;
        mul_a      = LEAK_C;
        mul_b      = sext(y[ch]);
        dx         = '0;
        // Zero-order hold: the input step only enters on the first sub-step.
        if (sub == '0)
            dx = sext(x_new[ch]) - sext(x_prev[ch]);
        case (state)
            IDLE:   if (audio_clk_en) state_next = LEAK;
            LEAK:   state_next = ALPHA;
            ALPHA: begin
                state_next = STORE;
                mul_a      = ALPHA_C;
                mul_b      = t_p0 + dx;
            end
            STORE:  state_next = (last_sub && last_ch) ? COMMIT : LEAK;
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ch             <= '0;
            sub            <= '0;
            overrun        <= 1'b0;
            vld_p0         <= 1'b0;
            out_valid      <= 1'b0;
            out            <= '0;
            bypass_latched <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                y[i]      <= '0;
                x_prev[i] <= '0;
            end
        end else begin
            state     <= state_next;
            vld_p0    <= (state == COMMIT);
            out_valid <= vld_p0;
            if (audio_clk_en && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (audio_clk_en) begin
                        for (int i = 0; i < CHANNELS; i++)
                            x_new[i] <= in[i*DATA_WIDTH +: DATA_WIDTH];
                        bypass_latched <= bypass;
                        ch             <= '0;
                        sub            <= '0;
                    end
                end
                LEAK:  t_p0 <= mul_q;
                ALPHA: p_p1 <= mul_q;
                STORE: begin
                    y[ch] <= sat(p_p1);
                    if (last_sub) begin
                        x_prev[ch] <= x_new[ch];
                        sub        <= '0;
                        if (!last_ch)
                            ch <= ch + 1'b1;
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
                COMMIT: begin
                    // Filter state keeps running under bypass so un-bypassing is click-free.
                    for (int i = 0; i < CHANNELS; i++)
                        res_p0[i] <= bypass_latched ? x_new[i] : y[i];
                end
                default: ;
            endcase
            // Output stage.
            if (vld_p0) begin
                for (int i = 0; i < CHANNELS; i++)
                    out[i*DATA_WIDTH +: DATA_WIDTH] <= res_p0[i];
            end
        end
    end
endmodule

// File: tb/tb_multichannel_rc_high_pass_filter.sv
// Directed bench for multichannel_rc_high_pass_filter (CH=2, DW=16, OS=1) with a
// sample-level behavioural model checked every cycle plus hand-computed literals.
module tb_multichannel_rc_high_pass_filter;
    localparam int     DW    = 16;
    localparam int     CH    = 2;
    localparam int     OS    = 1;
    localparam int     LAT   = 3 * CH * OS + 2;
    localparam longint LEAK  = 65520;
    localparam longint ALPHA = 65527;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              audio_clk_en = 1'b0;
    logic              bypass = 1'b0;
    logic [CH*DW-1:0]  in = '0;
    logic [CH*DW-1:0]  out;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    multichannel_rc_high_pass_filter dut (
        .clk(clk), .reset(reset), .audio_clk_en(audio_clk_en), .bypass(bypass),
        .in(in), .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    bit chk_en = 1'b0;

    typedef struct { int c; longint o0; longint o1; } res_t;
    res_t   q[$];
    longint y_m [CH];
    longint xp_m[CH];
    longint exp_o0 = 0, exp_o1 = 0;
    int     last_k = -1000;
    int     ovr_from = 1 << 30;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // One audio sample through the RC high-pass difference equation.
    task automatic model_run(input longint x0, input longint x1, input bit byp, input int k);
        longint xs[CH];
        longint o[CH];
        longint t, dx;
        res_t r;
        xs[0] = x0;
        xs[1] = x1;
        for (int c = 0; c < CH; c++) begin
            for (int s = 0; s < OS; s++) begin
                t  = (LEAK * y_m[c]) >>> 16;
                dx = (s == 0) ? xs[c] - xp_m[c] : 0;
                y_m[c] = clamp((ALPHA * (t + dx)) >>> 16);
            end
            xp_m[c] = xs[c];
            o[c] = byp ? xs[c] : y_m[c];
        end
        r.c = k + LAT; r.o0 = o[0]; r.o1 = o[1];
        q.push_back(r);
    endtask

    always @(negedge clk) begin
        bit ev;
        if (out_valid) n_pulse++;
        if (chk_en) begin
            ev = 1'b0;
            if (q.size() > 0 && q[0].c == cyc) begin
                ev = 1'b1;
                exp_o0 = q[0].o0;
                exp_o1 = q[0].o1;
                void'(q.pop_front());
            end
            check("out_valid", out_valid, ev);
            check("out_ch0", $signed(out[DW-1:0]), exp_o0);
            check("out_ch1", $signed(out[2*DW-1:DW]), exp_o1);
            check("busy", busy, (cyc >= last_k && cyc <= last_k + LAT - 2));
            check("overrun", overrun, (cyc >= ovr_from));
        end
    end

    // Called at posedge+1; the strobe is sampled on the next edge, index k.
    task automatic strobe(input longint x0, input longint x1, input bit byp, output int k);
        in = {16'(x1), 16'(x0)};
        bypass = byp;
        audio_clk_en = 1'b1;
        k = cyc + 1;
        if (k <= last_k + LAT - 1) begin
            if (ovr_from > k) ovr_from = k;
        end else begin
            model_run(x0, x1, byp, k);
            last_k = k;
        end
        @(posedge clk); #1;
        audio_clk_en = 1'b0;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < CH; c++) begin
            y_m[c] = 0;
            xp_m[c] = 0;
        end
        q.delete();
        last_k = -1000;
        ovr_from = 1 << 30;
        exp_o0 = 0;
        exp_o1 = 0;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(output longint o0, output longint o1, output int vc);
        bit got;
        got = 1'b0;
        o0 = 0; o1 = 0; vc = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                o0 = $signed(out[DW-1:0]);
                o1 = $signed(out[2*DW-1:DW]);
                vc = cyc;
            end
        end
        if (!got) check("out_valid_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int k, k2, vc;
        longint o0, o1, prev;

        @(posedge clk); #1;
        do_reset();
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1;

        // 1: step on ch0
        strobe(10000, 0, 0, k);
        wait_valid(o0, o1, vc);
        check("t1_latency", vc - k, 8);
        check("t1_ch0", o0, 9998);
        check("t1_ch1", o1, 0);

        // 2: held input decays toward zero
        prev = o0;
        for (int i = 0; i < 1000; i++) begin
            strobe(10000, 0, 0, k);
            wait_valid(o0, o1, vc);
            check("t2_decreasing", (o0 < prev), 1);
            check("t2_nonneg", (o0 >= 0), 1);
            check("t2_ch1", o1, 0);
            prev = o0;
        end

        // 3: full-scale negative then full-scale positive step saturates
        do_reset();
        strobe(-32768, 0, 0, k);
        wait_valid(o0, o1, vc);
        check("t3_neg", o0, -32764);
        strobe(32767, 0, 0, k);
        wait_valid(o0, o1, vc);
        check("t3_sat", o0, 32767);
        check("t3_ch1", o1, 0);

        // 4: bypass, then filter resumes from kept state
        do_reset();
        strobe(1234, -5, 1, k);
        wait_valid(o0, o1, vc);
        check("t4_byp_ch0", o0, 1234);
        check("t4_byp_ch1", o1, -5);
        strobe(1234, -5, 0, k);
        wait_valid(o0, o1, vc);
        check("t4_filt_ch0", o0, 1231);
        check("t4_filt_ch1", o1, -5);

        // 5: strobe while busy is dropped
        do_reset();
        n_pulse = 0;
        strobe(10000, 0, 0, k);
        idle(2);
        strobe(-20000, 5, 0, k2);
        check("t5_gap", k2 - k, 3);
        wait_valid(o0, o1, vc);
        check("t5_ch0", o0, 9998);
        check("t5_ch1", o1, 0);
        idle(12);
        check("t5_pulses", n_pulse, 1);
        check("t5_overrun_sticky", overrun, 1);

        // 6: reset mid-run aborts and clears history
        do_reset();
        strobe(10000, 0, 0, k);
        idle(3);
        do_reset();
        n_pulse = 0;
        idle(12);
        check("t6_no_pulse", n_pulse, 0);
        check("t6_out", out, 0);
        check("t6_busy", busy, 0);
        strobe(10000, 0, 0, k);
        wait_valid(o0, o1, vc);
        check("t6_ch0", o0, 9998);
        check("t6_ch1", o1, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
